// File: rtl/soc_dbus.sv
// soc_dbus: data-bus interconnect between the CPU data port and NSLV
// memory-mapped slaves. A request is address-decoded to one slave, held for
// that slave's programmed number of wait states, then acknowledged to the CPU
// with a one-cycle ready pulse. Accesses that decode to no slave complete
// immediately with an error flag, and their address and a saturating count
// are kept for debug.
//
// Parameters:
//   DW, AW        data / address width
//   NSLV          number of slaves (1..2^SLV_BITS)
//   SLV_BITS      width of the slave index field in the address
//   REGION_SHIFT  LSB position of the slave index field
//   WAITS         packed 4-bit wait-state counts, slave i at [4i+3:4i]
//
// Ports:
//   clock, nreset          clock (rising edge), async active-low reset
//   cpu_req/write/addr/wval  CPU request, held stable until cpu_ready
//   cpu_rval/ready/err     CPU completion: read data, ready pulse, error
//   s_sel/we/addr/wval     slave select (one-hot), write strobe, latched
//                          address and write data
//   s_rval                 slave read data, slave i at [DW*i+DW-1:DW*i]
//   err_addr, err_count    last unmapped address, saturating error count
module soc_dbus #(
  parameter int                DW           = 32,
  parameter int                AW           = 32,
  parameter int                NSLV         = 4,
  parameter int                SLV_BITS     = 2,
  parameter int                REGION_SHIFT = 28,
  parameter logic [NSLV*4-1:0] WAITS        = '0
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 cpu_req,
  input  logic                 cpu_write,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wval,
  output logic [DW-1:0]        cpu_rval,
  output logic                 cpu_ready,
  output logic                 cpu_err,
  output logic [NSLV-1:0]      s_sel,
  output logic                 s_we,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wval,
  input  logic [NSLV*DW-1:0]   s_rval,
  output logic [AW-1:0]        err_addr,
  output logic [7:0]           err_count
);

  localparam int TOP = REGION_SHIFT + SLV_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [SLV_BITS-1:0]   idx_q, idx_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wval_q, wval_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [AW-1:0]         err_addr_q, err_addr_d;
  logic [7:0]            err_count_q, err_count_d;

  logic [SLV_BITS-1:0]   req_idx;
  logic                  req_mapped;
  logic [DW-1:0]         sel_rval;

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Loop lookup keeps every part-select in range even for indices >= NSLV.
  function automatic logic [3:0] wait_of(input logic [SLV_BITS-1:0] i);
    logic [3:0] w;
    w = '0;
    for (int k = 0; k < NSLV; k++)
      if (int'(i) == k) w = WAITS[4*k +: 4];
    return w;
  endfunction

  assign req_idx = cpu_addr[TOP-1:REGION_SHIFT];
  // Everything above the index field must be zero for a mapped access.
  assign req_mapped = (int'(req_idx) < NSLV) && ((cpu_addr >> TOP) == '0);

  always_comb begin
    sel_rval = '0;
    for (int k = 0; k < NSLV; k++)
      if (int'(idx_q) == k) sel_rval = s_rval[DW*k +: DW];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wval_d      = wval_q;
    rdata_d     = rdata_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_write;
          wval_d  = cpu_wval;
          idx_d   = req_idx;
          rdata_d = '0;
          if (req_mapped) begin
            cnt_d   = wait_of(req_idx);
            err_d   = 1'b0;
            state_d = ACCESS;
          end else begin
            err_d       = 1'b1;
            err_addr_d  = cpu_addr;
            err_count_d = sat_inc8(err_count_q);
            state_d     = RESP;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = sel_rval;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wval_q      <= '0;
      rdata_q     <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wval_q      <= wval_d;
      rdata_q     <= rdata_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  // Outputs decode from registered state, so an async reset clears them at once.
  always_comb begin
    s_sel = '0;
    if (state_q == ACCESS)
      for (int k = 0; k < NSLV; k++)
        s_sel[k] = (int'(idx_q) == k);
  end

  assign s_we      = (state_q == ACCESS) && (cnt_q == 4'd0) && we_q;
  assign cpu_ready = (state_q == RESP);
  assign cpu_err   = (state_q == RESP) && err_q;
  // Cleared on every accept, so it reads 0 for writes and errors.
  assign cpu_rval  = rdata_q;
  assign s_addr    = addr_q;
  assign s_wval    = wval_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_soc_dbus.sv
module tb_soc_dbus;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int NSLV = 3;

  logic                 clock = 1'b0;
  logic                 nreset = 1'b0;
  logic                 cpu_req = 1'b0;
  logic                 cpu_write = 1'b0;
  logic [AW-1:0]        cpu_addr = '0;
  logic [DW-1:0]        cpu_wval = '0;
  logic [DW-1:0]        cpu_rval;
  logic                 cpu_ready;
  logic                 cpu_err;
  logic [NSLV-1:0]      s_sel;
  logic                 s_we;
  logic [AW-1:0]        s_addr;
  logic [DW-1:0]        s_wval;
  logic [NSLV*DW-1:0]   s_rval = {32'hCAFE0002, 32'hDEADBEEF, 32'h11110000};
  logic [AW-1:0]        err_addr;
  logic [7:0]           err_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  soc_dbus #(
    .DW(DW), .AW(AW), .NSLV(NSLV), .SLV_BITS(2), .REGION_SHIFT(28),
    .WAITS(12'h310)
  ) dut (
    .clock(clock), .nreset(nreset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wval(cpu_wval), .cpu_rval(cpu_rval), .cpu_ready(cpu_ready),
    .cpu_err(cpu_err), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr),
    .s_wval(s_wval), .s_rval(s_rval), .err_addr(err_addr),
    .err_count(err_count)
  );

  task automatic test_reset();
    nreset = 1'b0; cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h1000_0040;
    repeat (2) @(negedge clock);
    n_cmp++; if ({cpu_ready, cpu_err, s_we, s_sel} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {cpu_ready, cpu_err, s_we, s_sel}); end
    n_cmp++; if (cpu_rval !== 32'h0) begin
      n_fail++; $display("FAIL reset_rval: got %h expected 0", cpu_rval); end
    n_cmp++; if ({s_addr, s_wval} !== 64'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h/%h expected 0/0", s_addr, s_wval); end
    n_cmp++; if ({err_addr, err_count} !== 40'h0) begin
      n_fail++; $display("FAIL reset_err: got %h/%0d expected 0/0", err_addr, err_count); end
    nreset = 1'b1;
    @(negedge clock);
    n_cmp++; if (s_sel !== 3'b010) begin
      n_fail++; $display("FAIL reset_first_req: s_sel got %b expected 010", s_sel); end
    repeat (2) @(negedge clock);
    n_cmp++; if (cpu_ready !== 1'b1 || cpu_rval !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL reset_first_done: got rdy=%b rval=%h expected 1/deadbeef", cpu_ready, cpu_rval); end
    cpu_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_read();
    logic [2:0] esel [4] = '{3'b000, 3'b010, 3'b010, 3'b000};
    logic       erdy [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h1000_0040;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      n_cmp++; if (s_sel !== esel[c] || cpu_ready !== erdy[c] || s_we !== 1'b0) begin
        n_fail++; $display("FAIL read_c%0d: got sel=%b rdy=%b we=%b expected sel=%b rdy=%b we=0", c, s_sel, cpu_ready, s_we, esel[c], erdy[c]); end
    end
    n_cmp++; if (cpu_rval !== 32'hDEADBEEF || cpu_err !== 1'b0) begin
      n_fail++; $display("FAIL read_data: got %h err=%b expected deadbeef err=0", cpu_rval, cpu_err); end
    n_cmp++; if (s_addr !== 32'h1000_0040) begin
      n_fail++; $display("FAIL read_addr: got %h expected 10000040", s_addr); end
    cpu_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write();
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h0000_0008; cpu_wval = 32'h1234_5678;
    @(negedge clock);
    n_cmp++; if (s_sel !== 3'b001 || s_we !== 1'b1 || cpu_ready !== 1'b0) begin
      n_fail++; $display("FAIL write_c1: got sel=%b we=%b rdy=%b expected 001/1/0", s_sel, s_we, cpu_ready); end
    n_cmp++; if (s_wval !== 32'h1234_5678 || s_addr !== 32'h8) begin
      n_fail++; $display("FAIL write_bus: got %h/%h expected 12345678/00000008", s_wval, s_addr); end
    @(negedge clock);
    n_cmp++; if (s_sel !== 3'b000 || s_we !== 1'b0 || cpu_ready !== 1'b1 || cpu_err !== 1'b0) begin
      n_fail++; $display("FAIL write_c2: got sel=%b we=%b rdy=%b err=%b expected 000/0/1/0", s_sel, s_we, cpu_ready, cpu_err); end
    n_cmp++; if (cpu_rval !== 32'h0) begin
      n_fail++; $display("FAIL write_rval: got %h expected 0", cpu_rval); end
    cpu_req = 1'b0; cpu_write = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [2] = '{32'h3000_0000, 32'h4000_0000};
    for (int i = 0; i < 2; i++) begin
      cpu_req = 1'b1; cpu_addr = addrs[i];
      @(negedge clock);
      n_cmp++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b1 || s_sel !== 3'b0 || s_we !== 1'b0) begin
        n_fail++; $display("FAIL unmapped_%0d: got rdy=%b err=%b sel=%b we=%b expected 1/1/000/0", i, cpu_ready, cpu_err, s_sel, s_we); end
      n_cmp++; if (cpu_rval !== 32'h0) begin
        n_fail++; $display("FAIL unmapped_rval_%0d: got %h expected 0", i, cpu_rval); end
      cpu_req = 1'b0;
      @(negedge clock);
      n_cmp++; if (cpu_ready !== 1'b0 || s_sel !== 3'b0) begin
        n_fail++; $display("FAIL unmapped_idle_%0d: got rdy=%b sel=%b expected 0/000", i, cpu_ready, s_sel); end
    end
    n_cmp++; if (err_count !== 8'd2 || err_addr !== 32'h4000_0000) begin
      n_fail++; $display("FAIL unmapped_log: got %0d/%h expected 2/40000000", err_count, err_addr); end
  endtask

  task automatic test_saturation();
    // 2 errors already logged; 298 more gives 300 total.
    for (int i = 0; i < 298; i++) begin
      cpu_req = 1'b1; cpu_addr = 32'h3000_0000 | 32'(i);
      @(negedge clock);
      cpu_req = 1'b0;
      @(negedge clock);
      if (i == 252) begin
        n_cmp++; if (err_count !== 8'd255) begin
          n_fail++; $display("FAIL sat_reach: got %0d expected 255", err_count); end
      end
    end
    n_cmp++; if (err_count !== 8'd255) begin
      n_fail++; $display("FAIL sat_hold: got %0d expected 255", err_count); end
    n_cmp++; if (err_addr !== 32'h3000_0129) begin
      n_fail++; $display("FAIL sat_addr: got %h expected 30000129", err_addr); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] esel [6] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000};
    logic       erdy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0010;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      n_cmp++; if (s_sel !== esel[c] || cpu_ready !== erdy[c]) begin
        n_fail++; $display("FAIL b2b_c%0d: got sel=%b rdy=%b expected sel=%b rdy=%b", c, s_sel, cpu_ready, esel[c], erdy[c]); end
      if (c == 2 || c == 5) begin
        n_cmp++; if (cpu_rval !== 32'h1111_0000) begin
          n_fail++; $display("FAIL b2b_rval_c%0d: got %h expected 11110000", c, cpu_rval); end
      end
    end
    cpu_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_access();
    int bad_we = 0;
    int bad_rdy = 0;
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h2000_0004; cpu_wval = 32'hAAAA_5555;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      n_cmp++; if (s_sel !== 3'b100 || s_we !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_c%0d: got sel=%b we=%b expected 100/0", c, s_sel, s_we); end
    end
    #2 nreset = 1'b0;
    #1;
    n_cmp++; if (s_sel !== 3'b0 || s_we !== 1'b0 || cpu_ready !== 1'b0 || s_addr !== 32'h0 || s_wval !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_async: got sel=%b we=%b rdy=%b addr=%h wval=%h expected all 0", s_sel, s_we, cpu_ready, s_addr, s_wval); end
    repeat (4) begin
      @(negedge clock);
      if (s_we !== 1'b0) bad_we++;
      if (cpu_ready !== 1'b0) bad_rdy++;
    end
    cpu_req = 1'b0; cpu_write = 1'b0;
    nreset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (s_we !== 1'b0) bad_we++;
      if (cpu_ready !== 1'b0) bad_rdy++;
    end
    n_cmp++; if (bad_we !== 0) begin
      n_fail++; $display("FAIL rstmid_we: got %0d strobe cycles expected 0", bad_we); end
    n_cmp++; if (bad_rdy !== 0) begin
      n_fail++; $display("FAIL rstmid_ready: got %0d ready cycles expected 0", bad_rdy); end
    cpu_req = 1'b1; cpu_addr = 32'h0000_0000;
    @(negedge clock);
    n_cmp++; if (s_sel !== 3'b001 || cpu_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle_c1: got sel=%b rdy=%b expected 001/0", s_sel, cpu_ready); end
    @(negedge clock);
    n_cmp++; if (cpu_ready !== 1'b1 || cpu_rval !== 32'h1111_0000 || err_count !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_idle_c2: got rdy=%b rval=%h cnt=%0d expected 1/11110000/0", cpu_ready, cpu_rval, err_count); end
    cpu_req = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_saturation();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
